// File: rtl/if_id_queue.sv
// ---------------------------------------------------------------------------
// IfIdQueue: DEPTH-entry instruction queue between the fetch and decode
// stages. It replaces the plain IF-ID pipeline register: fetch can keep
// running while decode is stalled, until the queue fills.
//
// Ports:
//   clk       clock; all state updates on the rising edge
//   rst       asynchronous, active-low reset
//   flush     synchronous queue clear (exception / branch redirect)
//   if_valid  fetch presents a valid pc/inst pair this cycle
//   if_pc     PC of the fetched instruction
//   if_inst   fetched instruction word
//   if_ready  queue can accept this cycle; fetch holds its PC when low
//   id_stall  decode stalled; the head entry is held
//   id_valid  head entry valid
//   id_pc     head PC, zero when the queue is empty
//   id_inst   head instruction, zero when the queue is empty
//   count     current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module if_id_queue #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              if_valid,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic [INST_W-1:0] if_inst,
  output logic              if_ready,
  input  logic              id_stall,
  output logic              id_valid,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst,
  output logic [CNT_W-1:0]  count
);

  // DEPTH is a power of two, so the pointers wrap for free.
  localparam int PTR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] r_memPc   [DEPTH];
  logic [INST_W-1:0] r_memInst [DEPTH];
  logic [PTR_W-1:0]  r_rdPtr;
  logic [PTR_W-1:0]  r_wrPtr;
  logic [CNT_W-1:0]  r_cnt;

  logic w_push;
  logic w_pop;
  logic w_notEmpty;
  logic w_notFull;

  // Outputs decode from registers only, so there is no combinational path
  // from the fetch inputs to decode. An empty queue shows the all-zero NOP.
  always_comb begin
    w_notEmpty = (r_cnt != '0);
    w_notFull  = (r_cnt != CNT_W'(DEPTH));
    if_ready   = w_notFull;
    id_valid   = w_notEmpty;
    count      = r_cnt;
    id_pc      = '0;
    id_inst    = '0;
    if (w_notEmpty) begin
      id_pc   = r_memPc[r_rdPtr];
      id_inst = r_memInst[r_rdPtr];
    end
  end

  // Flush suppresses both handshakes so that nothing sneaks into or out of
  // the queue on the cycle it is cleared.
  always_comb begin
    w_push = if_valid & w_notFull & ~flush;
    w_pop  = w_notEmpty & ~id_stall & ~flush;
  end

  // Storage array needs no reset: entries are only visible once counted.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_memPc[r_wrPtr]   <= if_pc;
      r_memInst[r_wrPtr] <= if_inst;
    end
  end

  // Pointers and occupancy. A full queue blocks push even when a pop
  // happens in the same cycle, so the count can never pass DEPTH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_cnt   <= '0;
    end else if (flush) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_cnt   <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// ---------------------------------------------------------------------------
// Directed testbench for if_id_queue (DEPTH=4). Inputs change 1ns after the
// rising edge and outputs are sampled there as well.
// ---------------------------------------------------------------------------
module tb_if_id_queue;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_ready;
  logic        id_stall;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;

  if_id_queue #(
    .ADDR_W(32), .INST_W(32), .DEPTH(4), .CNT_W(3)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst), .if_ready(if_ready),
    .id_stall(id_stall), .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst),
    .count(count)
  );

  // 10ns clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction word derived from the PC so every entry is distinguishable.
  function automatic logic [31:0] instOf(input logic [31:0] pc);
    return 32'hA500_0000 ^ pc;
  endfunction

  // One comparison: counts it, and counts/reports a failure.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive the fetch/decode inputs for the next edge.
  task automatic applyStimulus(input logic valid, input logic [31:0] pc,
                               input logic stall, input logic fl);
    if_valid = valid;
    if_pc    = pc;
    if_inst  = instOf(pc);
    id_stall = stall;
    flush    = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Head entry check: pc, inst, valid and occupancy.
  task automatic checkHead(input string tag, input logic [31:0] pc,
                           input logic [2:0] cnt);
    checkOutput({tag, ".pc"},    id_pc,   pc);
    checkOutput({tag, ".inst"},  id_inst, instOf(pc));
    checkOutput({tag, ".valid"}, {31'b0, id_valid}, 32'd1);
    checkOutput({tag, ".count"}, {29'b0, count}, {29'b0, cnt});
  endtask

  task automatic checkEmpty(input string tag);
    checkOutput({tag, ".pc"},    id_pc,   32'h0);
    checkOutput({tag, ".inst"},  id_inst, 32'h0);
    checkOutput({tag, ".valid"}, {31'b0, id_valid}, 32'd0);
    checkOutput({tag, ".count"}, {29'b0, count}, 32'd0);
    checkOutput({tag, ".ready"}, {31'b0, if_ready}, 32'd1);
  endtask

  initial begin
    rst = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);

    // Reset state, before any clock edge.
    #3;
    checkEmpty("reset");

    // Release reset and push the first instruction.
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(1'b1, 32'h100, 1'b0, 1'b0);
    if_inst = 32'h3C01_0001;
    tick();
    checkOutput("first.pc",    id_pc,   32'h100);
    checkOutput("first.inst",  id_inst, 32'h3C01_0001);
    checkOutput("first.valid", {31'b0, id_valid}, 32'd1);
    checkOutput("first.count", {29'b0, count}, 32'd1);

    // Streaming: push and pop each cycle, head lags fetch by one cycle.
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, 32'h100 + 32'(4 * i), 1'b0, 1'b0);
      tick();
      checkHead("stream", 32'h100 + 32'(4 * i), 3'd1);
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    checkEmpty("streamDrain");

    // Fill with decode stalled: six attempts, only four accepted.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 32'h100 + 32'(4 * i), 1'b1, 1'b0);
      checkOutput("fill.ready", {31'b0, if_ready}, (i < 4) ? 32'd1 : 32'd0);
      tick();
      checkHead("fill", 32'h100, (i < 4) ? 3'(i + 1) : 3'd4);
    end
    checkOutput("full.ready", {31'b0, if_ready}, 32'd0);

    // Release the stall and drain in order; ready returns after first pop.
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    for (int j = 0; j < 4; j++) begin
      checkHead("drain", 32'h100 + 32'(4 * j), 3'(4 - j));
      tick();
      checkOutput("drain.ready", {31'b0, if_ready}, 32'd1);
    end
    checkEmpty("drained");

    // Fill again (pointers now wrap), then pop/push while full.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'h200 + 32'(4 * i), 1'b1, 1'b0);
      tick();
    end
    checkHead("full2", 32'h200, 3'd4);
    applyStimulus(1'b1, 32'h210, 1'b0, 1'b0);
    tick();
    checkHead("fullPopOnly", 32'h204, 3'd3);
    tick();
    checkHead("pushPop1", 32'h208, 3'd3);
    applyStimulus(1'b1, 32'h214, 1'b0, 1'b0);
    tick();
    checkHead("pushPop2", 32'h20C, 3'd3);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    checkHead("wrap1", 32'h210, 3'd2);
    tick();
    checkHead("wrap2", 32'h214, 3'd1);
    tick();
    checkEmpty("wrapDrained");

    // Flush with a concurrent push: everything is discarded.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'h300 + 32'(4 * i), 1'b1, 1'b0);
      tick();
    end
    checkHead("preFlush", 32'h300, 3'd3);
    applyStimulus(1'b1, 32'h30C, 1'b0, 1'b1);
    tick();
    checkEmpty("flush");
    applyStimulus(1'b1, 32'h310, 1'b1, 1'b0);
    tick();
    checkHead("postFlush", 32'h310, 3'd1);

    // Asynchronous reset between edges with two entries queued.
    applyStimulus(1'b1, 32'h314, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkHead("preReset", 32'h310, 3'd2);
    #2;
    rst = 1'b0;
    #1;
    checkEmpty("asyncReset");
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(1'b1, 32'h500, 1'b1, 1'b0);
    tick();
    checkHead("restart", 32'h500, 3'd1);
    applyStimulus(1'b1, 32'h504, 1'b0, 1'b0);
    tick();
    checkHead("restart2", 32'h504, 3'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Parametrised successor of the IF-ID pipeline register: a DEPTH-entry instruction queue between the fetch and decode stages.
- Fetch keeps running while decode is stalled, until the queue fills. Fetch is then back-pressured through if_ready.
- Decode sees the queue head as its {pc, inst} pair. A NOP (all-zero pair) is presented whenever the queue is empty, matching the existing bubble convention.
- flush empties the queue in one cycle, e.g. on exception or branch redirect.

Parameters:
ADDR_W, 32, width of the PC field (InstAddrBus)
INST_W, 32, width of the instruction field (InstBus)
DEPTH, 4, number of queue entries; power of two, at least 2
CNT_W, 3, width of the occupancy count; must equal log2(DEPTH)+1

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous, active-low reset
flush  in  1  synchronous queue clear; highest priority after reset
if_valid  in  1  fetch presents a valid pc/inst pair this cycle
if_pc  in  ADDR_W  PC of the fetched instruction
if_inst  in  INST_W  fetched instruction word
if_ready  out  1  queue can accept this cycle; fetch must hold its PC when low
id_stall  in  1  decode stalled (stall[2]); head entry is held
id_valid  out  1  head entry valid
id_pc  out  ADDR_W  head PC; zero when the queue is empty
id_inst  out  INST_W  head instruction; zero when the queue is empty
count  out  CNT_W  current occupancy, range 0..DEPTH

Behaviour:
- Storage: circular buffer of DEPTH entries with read pointer rd_ptr and write pointer wr_ptr, each log2(DEPTH) bits wide and wrapping modulo DEPTH, plus an occupancy register cnt (CNT_W bits).
- Reset: while rst=0, asynchronously set rd_ptr=0, wr_ptr=0, cnt=0. All outputs are then: id_valid=0, id_pc=0, id_inst=0, if_ready=1, count=0. Storage array contents are don't-care.
- Output decode (combinational, from registers only):
  - id_valid = (cnt!=0).
  - id_pc and id_inst = mem[rd_ptr] when id_valid, else 0.
  - if_ready = (cnt!=DEPTH).
  - count = cnt.
- push = if_valid & if_ready & ~flush.
- pop = id_valid & ~id_stall & ~flush.
- Clock edge priority, highest first:
  1. flush=1: rd_ptr=0, wr_ptr=0, cnt=0. Any concurrent push or pop is discarded.
  2. Otherwise:
     - push writes {if_pc, if_inst} to mem[wr_ptr] and increments wr_ptr.
     - pop increments rd_ptr.
     - cnt += push - pop.
- Latency: an entry pushed at edge k appears on id_* immediately after edge k, provided the queue was empty. This gives the same one-cycle IF→ID latency as the plain register. There is no same-cycle combinational bypass from if_* to id_*.
- Simultaneous push and pop:
  - Allowed whenever cnt is between 1 and DEPTH-1; cnt is unchanged.
  - When full, if_ready=0, so push is blocked even if a pop occurs that cycle. The freed slot becomes available on the next cycle.
  - When empty, pop cannot occur; a push makes cnt=1.
- Stall hold: with id_stall=1, id_pc and id_inst remain stable across edges. Fetch may keep pushing until cnt reaches DEPTH.
- Wrap-around: both pointers wrap from DEPTH-1 to 0. Ordering is strictly FIFO.
- Reset mid-operation: an asynchronous assert empties the queue immediately, independent of clk. Deassertion takes effect on the next clk edge.
- Invariants:
  - cnt never exceeds DEPTH and never underflows.
  - (wr_ptr - rd_ptr) mod DEPTH == cnt mod DEPTH.

Test Plan:
- Reset, then one push: rst=0 gives count=0, id_pc=0, id_inst=0, if_ready=1. After release, push pc=0x100, inst=0x3C010001. Next cycle id_valid=1, id_pc=0x100, id_inst=0x3C010001, count=1.
- Streaming: id_stall=0, if_valid=1 every cycle with pc 0x100, 0x104, 0x108, ... The id_pc sequence lags by one cycle, count stays 1, and no entry is dropped or duplicated.
- Fill/back-pressure: id_stall=1 while 6 pushes are attempted, DEPTH=4. Entries 0x100..0x10C are accepted, if_ready goes 0 after the 4th, count=4, id_pc is held at 0x100. Release the stall: drain order is 0x100, 0x104, 0x108, 0x10C, and if_ready returns to 1 one cycle after the first pop.
- Full plus simultaneous pop/push: queue full, id_stall=0, if_valid=1. Edge 1 pops only (count=3). Edge 2 pushes and pops (count stays 3). Pointer wrap past index 3 preserves order.
- Flush priority: queue holds 3 entries, flush=1 together with if_valid=1 and id_stall=0. Next cycle count=0, id_valid=0, id_pc=0, and the concurrent push is discarded. The following push becomes the new head.
- Asynchronous reset mid-stream: assert rst=0 between clock edges with count=2. Outputs clear immediately without a clk edge. After release, the first push restarts at index 0.
